rom_to_ram_copy_ctrl: RTL and testbench

- Sequencer that copies a block of N words from the registered-read ROM (rom_module) into RAM.
- Issues ROM read addresses, delays a valid/destination-address token by the ROM read latency, then issues aligned RAM writes.
- Start/done handshake plus synchronous abort. Replaces the fixed-range control_module in the data-delay environments and reuses the existing start_sig/done_sig pulse convention.

---
 rtl/copy_pkg.sv | 20 ++
 rtl/lat_delay_line.sv | 41 ++++
 rtl/rom_to_ram_copy_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_rom_to_ram_copy_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/copy_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// copy_pkg: shared state encoding and default sizing for the ROM-to-RAM copier.
// Rev 1.0
// ----------------------------------------------------------------------------
package copy_pkg;

  localparam int unsigned c_ADDR_W  = 4;
  localparam int unsigned c_DATA_W  = 8;
  localparam int unsigned c_ROM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lat_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lat_delay_line: fixed-depth shift register with synchronous flush.
// Rev 1.0
// ----------------------------------------------------------------------------
module lat_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [DEPTH*WIDTH-1:0] shift_q;
  logic [DEPTH*WIDTH-1:0] shift_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign shift_d = din_i;
    end else begin : g_multi
      assign shift_d = {shift_q[(DEPTH-1)*WIDTH-1:0], din_i};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (flush_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout_o = shift_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/rom_to_ram_copy_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_to_ram_copy_ctrl: copies N words from a registered-read ROM into RAM.
// Rev 1.0
// ----------------------------------------------------------------------------
module rom_to_ram_copy_ctrl
  import copy_pkg::*;
#(
  parameter int unsigned ADDR_W  = c_ADDR_W,
  parameter int unsigned DATA_W  = c_DATA_W,
  parameter int unsigned ROM_LAT = c_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_sig,
  input  logic              abort_sig,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done_sig,
  output logic              aborted
);

  localparam int unsigned TOK_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     iss_cnt_q, iss_cnt_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_rd_en_q, rom_rd_en_d;
  logic                write_en_q, write_en_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                flush;
  logic [TOK_W-1:0]    tok_in;
  logic [TOK_W-1:0]    tok_out;
  logic                tok_valid;
  logic [ADDR_W-1:0]   tok_off;

  // Token enters stage 0 alongside the issued read, so the last stage lines up
  // with the cycle in which that read's data is on rom_data.
  lat_delay_line #(
    .DEPTH (ROM_LAT + 1),
    .WIDTH (TOK_W)
  ) u_tok_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .din_i   (tok_in),
    .dout_o  (tok_out)
  );

  assign {tok_valid, tok_off} = tok_out;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    iss_cnt_d   = iss_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    dst_d       = dst_q;
    rom_addr_d  = rom_addr_q;
    rom_rd_en_d = 1'b0;
    write_en_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    aborted_d   = 1'b0;
    flush       = 1'b0;
    tok_in      = '0;

    if (tok_valid) begin
      write_en_d  = 1'b1;
      ram_addr_d  = dst_q + tok_off;
      ram_wdata_d = rom_data;
      wr_cnt_d    = wr_cnt_q + (ADDR_W+1)'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_sig) begin
          len_d     = length;
          dst_d     = dst_base;
          wr_cnt_d  = '0;
          iss_cnt_d = '0;
          if (length != '0) begin
            state_d     = ISSUE;
            rom_rd_en_d = 1'b1;
            rom_addr_d  = src_base;
            iss_cnt_d   = (ADDR_W+1)'(1);
            tok_in      = {1'b1, {ADDR_W{1'b0}}};
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE, DRAIN: begin
        if (abort_sig) begin
          // A write already on the outputs this cycle stands; nothing follows.
          flush       = 1'b1;
          write_en_d  = 1'b0;
          ram_addr_d  = ram_addr_q;
          ram_wdata_d = ram_wdata_q;
          wr_cnt_d    = wr_cnt_q;
          aborted_d   = 1'b1;
          state_d     = DONE;
        end else if (state_q == ISSUE) begin
          if (iss_cnt_q == len_q) begin
            state_d = DRAIN;
          end else begin
            rom_rd_en_d = 1'b1;
            rom_addr_d  = rom_addr_q + ADDR_W'(1);
            tok_in      = {1'b1, iss_cnt_q[ADDR_W-1:0]};
            iss_cnt_d   = iss_cnt_q + (ADDR_W+1)'(1);
          end
        end else if (write_en_q && (wr_cnt_q == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      dst_q       <= '0;
      rom_addr_q  <= '0;
      rom_rd_en_q <= 1'b0;
      write_en_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      iss_cnt_q   <= iss_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      dst_q       <= dst_d;
      rom_addr_q  <= rom_addr_d;
      rom_rd_en_q <= rom_rd_en_d;
      write_en_q  <= write_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_rd_en = rom_rd_en_q;
  assign write_en  = write_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign done_sig  = done_q;
  assign aborted   = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_to_ram_copy_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rom_to_ram_copy_ctrl: checks ROM_LAT=1 and ROM_LAT=3 copies against a schedule model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rom_to_ram_copy_ctrl;

  typedef struct packed {
    logic       rd;
    logic [3:0] ra;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       busy;
    logic       done;
    logic       ab;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_sig = 1'b0;
  logic       abort_sig = 1'b0;
  logic [3:0] src_base = '0;
  logic [3:0] dst_base = '0;
  logic [4:0] length = '0;

  logic [3:0] ra1, wa1, ra3, wa3;
  logic       rd1, we1, busy1, done1, ab1;
  logic       rd3, we3, busy3, done3, ab3;
  logic [7:0] wd1, wd3, rdata1, rdata3;

  int   cyc = 0;
  int   t0 = 0;
  int   sc_src, sc_dst, sc_len, sc_abort, sc_rst;
  logic [3:0] prev1, prev3;
  bit   active = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rel_c;
  obs_t a1, a3;
  obs_t log1 [40];
  obs_t log3 [40];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_val(input int a);
    return 8'(48 + 5 * (a % 16));
  endfunction

  // Registered-read ROMs: data appears ROM_LAT cycles after the address.
  logic [3:0] p1;
  logic [3:0] p3 [3];
  always @(posedge clk) begin
    p1    <= ra1;
    p3[0] <= ra3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata1 = rom_val(int'(p1));
  assign rdata3 = rom_val(int'(p3[2]));

  rom_to_ram_copy_ctrl #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_sig(start_sig), .abort_sig(abort_sig),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .rom_addr(ra1), .rom_rd_en(rd1), .rom_data(rdata1), .write_en(we1),
    .ram_addr(wa1), .ram_wdata(wd1), .busy(busy1), .done_sig(done1), .aborted(ab1)
  );

  rom_to_ram_copy_ctrl #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_sig(start_sig), .abort_sig(abort_sig),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .rom_addr(ra3), .rom_rd_en(rd3), .rom_data(rdata3), .write_en(we3),
    .ram_addr(wa3), .ram_wdata(wd3), .busy(busy3), .done_sig(done3), .aborted(ab3)
  );

  // Expected outputs at cycle rel of the current scenario (start sampled at rel 0).
  function automatic obs_t model(input int L, input int rel, input logic [3:0] prev);
    obs_t e;
    int   n_iss, last_busy, done_cyc, t;
    bit   ab;
    e = '0;
    if (sc_rst >= 0 && rel >= sc_rst) return e;
    e.ra = prev;
    ab = 1'b0;
    if (sc_len == 0) begin
      n_iss = 0; last_busy = 0; done_cyc = 1;
    end else begin
      n_iss = sc_len; last_busy = sc_len + L + 1; done_cyc = sc_len + L + 2;
      if (sc_abort >= 1 && sc_abort <= last_busy) begin
        last_busy = sc_abort;
        done_cyc  = sc_abort + 1;
        n_iss     = (sc_len < sc_abort) ? sc_len : sc_abort;
        ab        = 1'b1;
      end
    end
    if (rel >= 1 && n_iss > 0)
      e.ra = 4'((sc_src + ((rel <= n_iss) ? rel - 1 : n_iss - 1)) % 16);
    e.rd   = (rel >= 1 && rel <= n_iss);
    e.busy = (rel >= 1 && rel <= last_busy);
    e.done = (rel == done_cyc);
    e.ab   = e.done && ab;
    t = rel - L - 1;
    if (t >= 1 && t <= n_iss && rel <= last_busy) begin
      e.we = 1'b1;
      e.wa = 4'((sc_dst + t - 1) % 16);
      e.wd = rom_val((sc_src + t - 1) % 16);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input int rel, input obs_t a, input obs_t e);
    chk($sformatf("%s_rd@%0d", tag, rel), int'(a.rd), int'(e.rd));
    chk($sformatf("%s_rom_addr@%0d", tag, rel), int'(a.ra), int'(e.ra));
    chk($sformatf("%s_we@%0d", tag, rel), int'(a.we), int'(e.we));
    chk($sformatf("%s_busy@%0d", tag, rel), int'(a.busy), int'(e.busy));
    chk($sformatf("%s_done@%0d", tag, rel), int'(a.done), int'(e.done));
    chk($sformatf("%s_aborted@%0d", tag, rel), int'(a.ab), int'(e.ab));
    if (e.we) begin
      chk($sformatf("%s_ram_addr@%0d", tag, rel), int'(a.wa), int'(e.wa));
      chk($sformatf("%s_wdata@%0d", tag, rel), int'(a.wd), int'(e.wd));
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      rel_c = cyc - t0;
      a1 = '{rd1, ra1, we1, wa1, wd1, busy1, done1, ab1};
      a3 = '{rd3, ra3, we3, wa3, wd3, busy3, done3, ab3};
      cmp("L1", rel_c, a1, model(1, rel_c, prev1));
      cmp("L3", rel_c, a3, model(3, rel_c, prev3));
      if (rel_c >= 0 && rel_c < 40) begin
        log1[rel_c] = a1;
        log3[rel_c] = a3;
      end
    end
  end

  task automatic run(input int s, input int d, input int n, input int ab,
                     input int rs, input bit rp, input int ncyc);
    obs_t e;
    sc_src = s; sc_dst = d; sc_len = n; sc_abort = ab; sc_rst = rs;
    t0 = cyc;
    active = 1'b1;
    src_base  = 4'(s);
    dst_base  = 4'(d);
    length    = 5'(n);
    start_sig = 1'b1;
    abort_sig = (ab == 0);
    for (int r = 1; r <= ncyc; r++) begin
      @(posedge clk);
      #1;
      start_sig = rp && (r == 2 || r == 7);
      src_base  = 4'(s + 7);
      dst_base  = 4'(d + 3);
      length    = 5'd1;
      abort_sig = (r == ab);
      if (r == rs) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd", int'(rd1), 0);
        chk("rst_mid_we", int'(we1), 0);
        chk("rst_mid_busy", int'(busy3), 0);
        chk("rst_mid_rom_addr", int'(ra1), 0);
        chk("rst_mid_ram_addr", int'(wa3), 0);
      end
      if (r == rs + 2) rst_n = 1'b1;
    end
    e = model(1, 1000, prev1);
    prev1 = e.ra;
    e = model(3, 1000, prev3);
    prev3 = e.ra;
  endtask

  initial begin
    prev1 = '0;
    prev3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", int'(rd1), 0);
    chk("reset_busy", int'(busy1), 0);
    chk("reset_done", int'(done3), 0);
    chk("reset_we", int'(we3), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 8, 4, -1, -1, 1'b0, 14);
    chk("t1_we3", int'(log1[3].we), 1);
    chk("t1_waddr3", int'(log1[3].wa), 8);
    chk("t1_wdata3", int'(log1[3].wd), 8'h30);
    chk("t1_waddr6", int'(log1[6].wa), 11);
    chk("t1_wdata6", int'(log1[6].wd), 8'h3F);
    chk("t1_romaddr2", int'(log1[2].ra), 1);
    chk("t1_done7", int'(log1[7].done), 1);
    chk("t1_busy7", int'(log1[7].busy), 0);
    chk("t1_L3_done9", int'(log3[9].done), 1);

    run(14, 15, 3, -1, -1, 1'b0, 12);
    chk("t2_romaddr3", int'(log1[3].ra), 0);
    chk("t2_waddr3", int'(log1[3].wa), 15);
    chk("t2_wdata3", int'(log1[3].wd), 8'h76);
    chk("t2_waddr5", int'(log1[5].wa), 1);
    chk("t2_wdata5", int'(log1[5].wd), 8'h30);

    run(3, 2, 0, 1, -1, 1'b0, 5);
    chk("t3_done1", int'(log1[1].done), 1);
    chk("t3_aborted1", int'(log1[1].ab), 0);
    chk("t3_rd1", int'(log1[1].rd), 0);

    run(0, 8, 4, 3, -1, 1'b0, 10);
    chk("t4_we3", int'(log1[3].we), 1);
    chk("t4_we4", int'(log1[4].we), 0);
    chk("t4_rd4", int'(log1[4].rd), 0);
    chk("t4_done4", int'(log1[4].done), 1);
    chk("t4_aborted4", int'(log1[4].ab), 1);
    chk("t4_L3_done4", int'(log3[4].done), 1);

    run(6, 1, 4, -1, -1, 1'b1, 14);
    chk("t5_done7", int'(log1[7].done), 1);
    chk("t5_busy8", int'(log1[8].busy), 0);

    run(2, 4, 4, -1, 4, 1'b0, 12);

    run(9, 12, 2, 0, -1, 1'b0, 12);
    chk("t7_L3_we4", int'(log3[4].we), 0);
    chk("t7_L3_we5", int'(log3[5].we), 1);
    chk("t7_L3_we6", int'(log3[6].we), 1);
    chk("t7_L3_done7", int'(log3[7].done), 1);
    chk("t7_L3_wdata5", int'(log3[5].wd), 8'h5D);

    run(5, 3, 16, -1, -1, 1'b0, 26);
    chk("t8_L1_done19", int'(log1[19].done), 1);

    active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
